usb_endp_router: RTL and testbench
==================================

// Module: usb_endp_router
// PURPOSE
//  Parametrised endpoint router between the SIE and the control/bulk endpoints of a multi-channel CDC device.
//  Holds the endpoint selection for the whole transaction and keeps per-channel ENDPOINT_HALT state.
//  Generates a zero-length packet (ZLP) after a full-size bulk IN packet when no more data is queued.
//  Replaces the combinational endpoint mux used at the CDC top level.
// PARAMETERS
//  CHANNELS          1   number of bulk channels, 1..7
//  ENDP_BASE         1   endpoint number of channel 0
//  ENDP_STRIDE       2   endpoint number of channel j = ENDP_BASE+ENDP_STRIDE*j, must be <=15
//  IN_BULK_MAXPACKETSIZE 8  bulk IN max packet size in bytes: 8, 16, 32 or 64
//  ZLP_EN            1   1 = automatic ZLP after a full-size packet; 0 = in_zlp_o driven by ctrl only
// PORTS
//  clk_i              in   1          12MHz*BIT_SAMPLES clock
//  rstn_i             in   1          asynchronous reset, active low
//  clk_gate_i         in   1          one-cycle bit-rate enable; all state updates are qualified by it
//  bus_reset_i        in   1          USB bus reset from the SIE
//  endp_i             in   4          current token endpoint from the SIE
//  in_req_i/in_ready_i/out_ready_i/in_data_ack_i  in 1  SIE transaction strobes
//  in_data_o          out  8          IN byte to the SIE
//  in_valid_o/in_zlp_o/out_nak_o/stall_o  out 1  endpoint status to the SIE
//  ctrl_in_data_i     in   8          control endpoint IN byte
//  ctrl_in_valid_i/ctrl_in_zlp_i/ctrl_stall_i  in 1  control endpoint status
//  ctrl_in_req_o/ctrl_in_ready_o/ctrl_out_ready_o  out 1  routed strobes to the control endpoint
//  bulk_in_data_i     in   8*CHANNELS per-channel IN byte
//  bulk_in_valid_i/bulk_out_nak_i  in CHANNELS  per-channel status
//  bulk_in_req_o/bulk_in_ready_o/bulk_out_ready_o  out CHANNELS  routed strobes to the bulk endpoints
//  halt_set_i/halt_clr_i  in  1       from ctrl_endp: SET_FEATURE / CLEAR_FEATURE(ENDPOINT_HALT)
//  halt_endp_i        in   4          endpoint addressed by the halt request
//  halted_o           out  CHANNELS   per-channel halt state
//  toggle_reset_o     out  16         one-clk_gate pulse per endpoint; OR-ed into the SIE toggle resets
// BEHAVIOUR
//  Reset (rstn_i low or bus_reset_i): state IDLE, halted_o=0, ZLP pending=0, byte counters=0,
//   toggle_reset_o=0. All other outputs are combinational; with selection=ctrl they reflect ctrl_* inputs.
//  FSM IDLE/BUSY:
//   - IDLE->BUSY when in_req_i or in_ready_i or out_ready_i is high on a clk_gate; sel_q <= decode(endp_i).
//   - BUSY->IDLE on a clk_gate with in_req_i, in_ready_i and out_ready_i all low.
//   - Selection = decode(endp_i) in IDLE, sel_q in BUSY; endp_i changes mid-transaction are ignored.
//  Decode: endp 0 -> ctrl; ENDP_BASE+ENDP_STRIDE*j with j<CHANNELS -> channel j; anything else is unmapped.
//  Routing: strobes go only to the selected target, all others 0. in_data_o/in_valid_o/out_nak_o come from the target.
//  Halted channel or unmapped endpoint:
//   - stall_o=1, in_valid_o=0, out_nak_o=0, in_zlp_o=0.
//   - No strobes are forwarded.
//  Halt control, applied on clk_gate:
//   - halt_set_i sets halted[j] for the matching endpoint.
//   - halt_clr_i clears halted[j] and pulses toggle_reset_o[endp], even when the channel was not halted.
//   - Both high at once: clear wins.
//   - Endpoint 0 and unmapped endpoints are ignored.
//  ZLP (ZLP_EN=1), per channel j:
//   - cnt_j, width ceil_log2(MAX+1), increments on clk_gate & bulk_in_ready_o[j] & bulk_in_valid_i[j].
//   - in_data_ack_i while j is selected: pend_j <= (cnt_j==MAX); cnt_j <= 0.
//   - IN to j with pend_j=1 and bulk_in_valid_i[j]=0: in_zlp_o=1, and pend_j clears on that ack.
//   - If valid data is present it is sent normally; pend_j is then re-evaluated at that ack.
//   - No ack (NAK/timeout): pend_j and cnt_j are unchanged (retry replays the same packet).
//  A transaction in flight when reset occurs is abandoned; no strobe is forwarded after reset.
// STRUCTURE
//  Shared package usb_cdc_pkg: ENDP_CTRL=0, the endpoint->channel decode function and ceil_log2.
//  One sub-module, usb_endp_chan_state, instantiated once per channel in a generate loop:
//   holds halted, cnt, pend and the toggle-reset pulse. The top holds the FSM and the muxes.
// TESTING
//  1 CHANNELS=3, endp_i=5, IN of 4 bytes -> only bulk_in_req_o[2] high; 4 in_ready pulses; after ack pend_2=0.
//  2 MAX=8, 8-byte IN acked, then IN with bulk_in_valid_i[0]=0 -> in_zlp_o=1; after ack pend_0=0.
//  3 halt_set_i with halt_endp_i=3 -> halted_o[1]=1, IN/OUT to ep3 stall_o=1;
//    halt_clr_i -> halted_o[1]=0 and toggle_reset_o[3] high for one clk_gate.
//  4 endp_i switches 1->3 during BUSY -> strobes stay on channel 0 until IDLE.
//  5 endp_i=9 with CHANNELS=2 -> stall_o=1, no strobes; endp_i=0 -> ctrl_* passed through unchanged.
//  6 bus_reset_i during an 8-byte IN with pend set -> state IDLE, pend=0, halted_o=0, counters 0.

Source files
------------

// File: rtl/usb_cdc_pkg.sv
// Shared definitions for the CDC endpoint router: router states, endpoint decode
// and sizing helpers.
package usb_cdc_pkg;

    localparam logic [3:0] ENDP_CTRL    = 4'd0;
    localparam int         MAX_CHANNELS = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } router_state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic       is_bulk;
        logic [2:0] chan;
    } endp_sel_t;

    function automatic int ceil_log2(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic [3:0] chan_endp(input int base, input int stride, input int j);
        return 4'(base + stride * j);
    endfunction

    function automatic endp_sel_t decode_endp(input logic [3:0] endp, input int base,
                                              input int stride, input int channels);
        endp_sel_t sel;
        sel = '0;
        if (endp == ENDP_CTRL) begin
            sel.is_ctrl = 1'b1;
        end else begin
            for (int j = 0; j < MAX_CHANNELS; j++) begin
                if (j < channels && endp == chan_endp(base, stride, j)) begin
                    sel.is_bulk = 1'b1;
                    sel.chan    = 3'(j);
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/usb_endp_chan_state.sv
// Per-channel bulk endpoint state: ENDPOINT_HALT flag, IN byte counter, pending-ZLP
// flag and the data-toggle reset pulse raised by CLEAR_FEATURE(ENDPOINT_HALT).
module usb_endp_chan_state
    import usb_cdc_pkg::*;
#(
    parameter int MAX_PKT = 8,
    parameter bit ZLP_EN  = 1'b1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clk_gate_i,
    input  logic bus_reset_i,
    input  logic sel_i,
    input  logic in_ready_i,
    input  logic in_valid_i,
    input  logic in_data_ack_i,
    input  logic halt_set_i,
    input  logic halt_clr_i,
    output logic halted_o,
    output logic pend_o,
    output logic toggle_reset_o
);

    localparam int               CNT_W   = ceil_log2(MAX_PKT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_halted;
    logic             r_toggle;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_halted <= 1'b0;
            r_toggle <= 1'b0;
        end else if (bus_reset_i) begin
            r_halted <= 1'b0;
            r_toggle <= 1'b0;
        end else if (clk_gate_i) begin
            r_toggle <= halt_clr_i;
            if (halt_clr_i) r_halted <= 1'b0;
            else if (halt_set_i) r_halted <= 1'b1;
        end
    end

    // An unacknowledged packet leaves cnt/pend alone so the retry replays it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (bus_reset_i) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (clk_gate_i) begin
            if (sel_i && in_data_ack_i) begin
                r_pend <= (r_cnt == CNT_MAX);
                r_cnt  <= '0;
            end else if (in_ready_i && in_valid_i && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign halted_o       = r_halted;
    assign pend_o         = ZLP_EN && r_pend;
    assign toggle_reset_o = r_toggle;

endmodule

// File: rtl/usb_endp_router.sv
// Endpoint router between the SIE and the control/bulk endpoints: latches the
// selection for a whole transaction and applies per-channel halt and ZLP handling.
module usb_endp_router
    import usb_cdc_pkg::*;
#(
    parameter int CHANNELS              = 1,
    parameter int ENDP_BASE             = 1,
    parameter int ENDP_STRIDE           = 2,
    parameter int IN_BULK_MAXPACKETSIZE = 8,
    parameter bit ZLP_EN                = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clk_gate_i,
    input  logic                  bus_reset_i,
    input  logic [3:0]            endp_i,
    input  logic                  in_req_i,
    input  logic                  in_ready_i,
    input  logic                  out_ready_i,
    input  logic                  in_data_ack_i,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    output logic                  in_zlp_o,
    output logic                  out_nak_o,
    output logic                  stall_o,
    input  logic [7:0]            ctrl_in_data_i,
    input  logic                  ctrl_in_valid_i,
    input  logic                  ctrl_in_zlp_i,
    input  logic                  ctrl_stall_i,
    output logic                  ctrl_in_req_o,
    output logic                  ctrl_in_ready_o,
    output logic                  ctrl_out_ready_o,
    input  logic [8*CHANNELS-1:0] bulk_in_data_i,
    input  logic [CHANNELS-1:0]   bulk_in_valid_i,
    input  logic [CHANNELS-1:0]   bulk_out_nak_i,
    output logic [CHANNELS-1:0]   bulk_in_req_o,
    output logic [CHANNELS-1:0]   bulk_in_ready_o,
    output logic [CHANNELS-1:0]   bulk_out_ready_o,
    input  logic                  halt_set_i,
    input  logic                  halt_clr_i,
    input  logic [3:0]            halt_endp_i,
    output logic [CHANNELS-1:0]   halted_o,
    output logic [15:0]           toggle_reset_o
);

    router_state_t       r_state, w_state_nxt;
    endp_sel_t           r_sel_q, w_dec, w_sel;
    logic                w_any_strobe, w_blocked, w_fwd;
    logic [CHANNELS-1:0] w_bulk_sel, w_pend, w_chan_toggle, w_halt_set, w_halt_clr;

    assign w_any_strobe = in_req_i | in_ready_i | out_ready_i;
    assign w_dec        = decode_endp(endp_i, ENDP_BASE, ENDP_STRIDE, CHANNELS);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_sel_q <= '0;
        end else if (bus_reset_i) begin
            r_state <= ST_IDLE;
            r_sel_q <= '0;
        end else if (clk_gate_i) begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_strobe) r_sel_q <= w_dec;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_strobe)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (!w_any_strobe) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Mid-transaction endp_i changes are ignored once the selection is latched.
    assign w_sel = (r_state == ST_BUSY) ? r_sel_q : w_dec;

    always_comb begin
        for (int j = 0; j < CHANNELS; j++) begin
            w_bulk_sel[j] = w_sel.is_bulk && (w_sel.chan == 3'(j));
            w_halt_set[j] = halt_set_i && (halt_endp_i == chan_endp(ENDP_BASE, ENDP_STRIDE, j));
            w_halt_clr[j] = halt_clr_i && (halt_endp_i == chan_endp(ENDP_BASE, ENDP_STRIDE, j));
        end
    end

    assign w_blocked = !w_sel.is_ctrl && !(|(w_bulk_sel & ~halted_o));
    assign w_fwd     = !w_blocked && !bus_reset_i;

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        in_data_o        = '0;
        in_valid_o       = 1'b0;
        in_zlp_o         = 1'b0;
        out_nak_o        = 1'b0;
        stall_o          = 1'b0;
        ctrl_in_req_o    = 1'b0;
        ctrl_in_ready_o  = 1'b0;
        ctrl_out_ready_o = 1'b0;
        bulk_in_req_o    = '0;
        bulk_in_ready_o  = '0;
        bulk_out_ready_o = '0;
        if (w_blocked) begin
            stall_o = 1'b1;
        end else if (w_sel.is_ctrl) begin
            in_data_o        = ctrl_in_data_i;
            in_valid_o       = ctrl_in_valid_i;
            in_zlp_o         = ctrl_in_zlp_i;
            stall_o          = ctrl_stall_i;
            ctrl_in_req_o    = w_fwd && in_req_i;
            ctrl_in_ready_o  = w_fwd && in_ready_i;
            ctrl_out_ready_o = w_fwd && out_ready_i;
        end else begin
            for (int j = 0; j < CHANNELS; j++) begin
                if (w_bulk_sel[j]) begin
                    in_data_o           = bulk_in_data_i[8*j +: 8];
                    in_valid_o          = bulk_in_valid_i[j];
                    out_nak_o           = bulk_out_nak_i[j];
                    in_zlp_o            = w_pend[j] && !bulk_in_valid_i[j];
                    bulk_in_req_o[j]    = w_fwd && in_req_i;
                    bulk_in_ready_o[j]  = w_fwd && in_ready_i;
                    bulk_out_ready_o[j] = w_fwd && out_ready_i;
                end
            end
        end
    end

    always_comb begin
        toggle_reset_o = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            toggle_reset_o[chan_endp(ENDP_BASE, ENDP_STRIDE, j)] = w_chan_toggle[j];
        end
    end

    for (genvar j = 0; j < CHANNELS; j++) begin : g_chan
        usb_endp_chan_state #(
            .MAX_PKT (IN_BULK_MAXPACKETSIZE),
            .ZLP_EN  (ZLP_EN)
        ) u_state (
            .clk_i          (clk_i),
            .rstn_i         (rstn_i),
            .clk_gate_i     (clk_gate_i),
            .bus_reset_i    (bus_reset_i),
            .sel_i          (w_bulk_sel[j]),
            .in_ready_i     (bulk_in_ready_o[j]),
            .in_valid_i     (bulk_in_valid_i[j]),
            .in_data_ack_i  (in_data_ack_i),
            .halt_set_i     (w_halt_set[j]),
            .halt_clr_i     (w_halt_clr[j]),
            .halted_o       (halted_o[j]),
            .pend_o         (w_pend[j]),
            .toggle_reset_o (w_chan_toggle[j])
        );
    end

endmodule

// File: tb/tb_usb_endp_router.sv
// Self-checking bench for usb_endp_router: combinational routing table, directed
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_usb_endp_router;

    localparam int CH     = 3;
    localparam int BASE   = 1;
    localparam int STRIDE = 2;
    localparam int MAXP   = 8;

    logic          clk = 1'b0;
    logic          rstn, clk_gate, bus_reset;
    logic [3:0]    endp, halt_endp;
    logic          in_req, in_ready, out_ready, in_data_ack;
    logic [7:0]    in_data, ctrl_in_data;
    logic          in_valid, in_zlp, out_nak, stall;
    logic          ctrl_in_valid, ctrl_in_zlp, ctrl_stall;
    logic          ctrl_in_req, ctrl_in_ready, ctrl_out_ready;
    logic [8*CH-1:0] bulk_in_data;
    logic [CH-1:0] bulk_in_valid, bulk_out_nak, bulk_in_req, bulk_in_ready, bulk_out_ready;
    logic          halt_set, halt_clr;
    logic [CH-1:0] halted;
    logic [15:0]   toggle_reset;

    always #5 clk = ~clk;

    usb_endp_router #(
        .CHANNELS(CH), .ENDP_BASE(BASE), .ENDP_STRIDE(STRIDE),
        .IN_BULK_MAXPACKETSIZE(MAXP), .ZLP_EN(1'b1)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .clk_gate_i(clk_gate), .bus_reset_i(bus_reset),
        .endp_i(endp), .in_req_i(in_req), .in_ready_i(in_ready), .out_ready_i(out_ready),
        .in_data_ack_i(in_data_ack), .in_data_o(in_data), .in_valid_o(in_valid),
        .in_zlp_o(in_zlp), .out_nak_o(out_nak), .stall_o(stall),
        .ctrl_in_data_i(ctrl_in_data), .ctrl_in_valid_i(ctrl_in_valid),
        .ctrl_in_zlp_i(ctrl_in_zlp), .ctrl_stall_i(ctrl_stall),
        .ctrl_in_req_o(ctrl_in_req), .ctrl_in_ready_o(ctrl_in_ready),
        .ctrl_out_ready_o(ctrl_out_ready), .bulk_in_data_i(bulk_in_data),
        .bulk_in_valid_i(bulk_in_valid), .bulk_out_nak_i(bulk_out_nak),
        .bulk_in_req_o(bulk_in_req), .bulk_in_ready_o(bulk_in_ready),
        .bulk_out_ready_o(bulk_out_ready), .halt_set_i(halt_set), .halt_clr_i(halt_clr),
        .halt_endp_i(halt_endp), .halted_o(halted), .toggle_reset_o(toggle_reset)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference model
    bit            m_busy;
    int            m_sel;
    logic [CH-1:0] m_halted;
    logic [CH-1:0] m_pend;
    int            m_cnt [CH];
    logic [15:0]   m_toggle;

    // -1 = control endpoint, -2 = unmapped, otherwise the channel index
    function automatic int chan_of(input int ep);
        if (ep == 0) return -1;
        if (ep < BASE || (ep - BASE) % STRIDE != 0 || (ep - BASE) / STRIDE >= CH) return -2;
        return (ep - BASE) / STRIDE;
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_sel    = 0;
        m_halted = '0;
        m_pend   = '0;
        m_toggle = '0;
        for (int j = 0; j < CH; j++) m_cnt[j] = 0;
    endtask

    task automatic model_step();
        int  ep, c, hc;
        bit  any;
        if (bus_reset) begin
            model_reset();
            return;
        end
        any = in_req || in_ready || out_ready;
        ep  = m_busy ? m_sel : int'(endp);
        c   = chan_of(ep);
        if (c >= 0) begin
            if (in_data_ack) begin
                m_pend[c] = (m_cnt[c] == MAXP);
                m_cnt[c]  = 0;
            end else if (!m_halted[c] && in_ready && bulk_in_valid[c] && m_cnt[c] < MAXP) begin
                m_cnt[c]++;
            end
        end
        hc       = chan_of(int'(halt_endp));
        m_toggle = '0;
        if (hc >= 0 && halt_clr) begin
            m_halted[hc]        = 1'b0;
            m_toggle[halt_endp] = 1'b1;
        end else if (hc >= 0 && halt_set) begin
            m_halted[hc] = 1'b1;
        end
        if (!m_busy && any) begin
            m_busy = 1;
            m_sel  = int'(endp);
        end else if (m_busy && !any) begin
            m_busy = 0;
        end
    endtask

    task automatic check_model(input string tag);
        int         ep, c;
        logic [2:0] e_ctrl, e_breq, e_brdy, e_bordy;
        logic       e_stall, e_valid, e_zlp, e_nak;
        bit         fwd;
        ep = m_busy ? m_sel : int'(endp);
        c  = chan_of(ep);
        fwd = !bus_reset;
        e_ctrl = '0; e_breq = '0; e_brdy = '0; e_bordy = '0;
        e_stall = 0; e_valid = 0; e_zlp = 0; e_nak = 0;
        if (c == -1) begin
            e_stall = ctrl_stall;
            e_valid = ctrl_in_valid;
            e_zlp   = ctrl_in_zlp;
            e_ctrl  = fwd ? {in_req, in_ready, out_ready} : 3'b000;
            check({tag, "_data"}, in_data, ctrl_in_data);
        end else if (c == -2 || m_halted[c]) begin
            e_stall = 1;
        end else begin
            e_valid = bulk_in_valid[c];
            e_nak   = bulk_out_nak[c];
            e_zlp   = m_pend[c] && !bulk_in_valid[c];
            if (fwd) begin
                e_breq[c]  = in_req;
                e_brdy[c]  = in_ready;
                e_bordy[c] = out_ready;
            end
            check({tag, "_data"}, in_data, bulk_in_data[8*c +: 8]);
            check({tag, "_nak"}, out_nak, e_nak);
        end
        check({tag, "_stall"}, stall, e_stall);
        check({tag, "_valid"}, in_valid, e_valid);
        check({tag, "_zlp"}, in_zlp, e_zlp);
        check({tag, "_ctrl"}, {ctrl_in_req, ctrl_in_ready, ctrl_out_ready}, e_ctrl);
        check({tag, "_breq"}, bulk_in_req, e_breq);
        check({tag, "_brdy"}, bulk_in_ready, e_brdy);
        check({tag, "_bordy"}, bulk_out_ready, e_bordy);
        check({tag, "_halted"}, halted, m_halted);
        check({tag, "_toggle"}, toggle_reset, m_toggle);
    endtask

    // One clk_gate period: gated edge, then an ungated edge; returns on a negedge.
    task automatic tick();
        clk_gate = 1'b1;
        model_step();
        @(negedge clk);
        clk_gate = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_req = 0; in_ready = 0; out_ready = 0; in_data_ack = 0;
        halt_set = 0; halt_clr = 0; halt_endp = 4'd0; bus_reset = 0;
    endtask

    typedef struct {
        logic [3:0] endp;
        logic [2:0] strb;       // {in_req, in_ready, out_ready}
        logic [2:0] exp_ctrl;
        logic [2:0] exp_breq;
        logic [2:0] exp_brdy;
        logic [2:0] exp_bordy;
        logic       exp_stall;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_nak;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{4'd0,  3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{4'd0,  3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[2] = '{4'd1,  3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[3] = '{4'd3,  3'b100, 3'b000, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 8'h22, 1'b1};
        vecs[4] = '{4'd5,  3'b001, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b1, 8'h33, 1'b0};
        vecs[5] = '{4'd7,  3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{4'd9,  3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{4'd2,  3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{4'd15, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[9] = '{4'd0,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 8'hA5, 1'b0};

        rstn = 0; clk_gate = 0; endp = 4'd0;
        idle_inputs();
        ctrl_in_data = 8'hA5; ctrl_in_valid = 1; ctrl_in_zlp = 0; ctrl_stall = 0;
        bulk_in_data = 24'h332211; bulk_in_valid = 3'b101; bulk_out_nak = 3'b010;
        model_reset();
        #22;
        @(negedge clk);
        check("reset_halted", halted, 3'b000);
        check("reset_toggle", toggle_reset, 16'h0000);
        check("reset_bulk_req", bulk_in_req, 3'b000);
        rstn = 1;
        @(negedge clk);

        // Combinational routing in IDLE, nothing halted
        for (int i = 0; i < 10; i++) begin
            endp = vecs[i].endp;
            {in_req, in_ready, out_ready} = vecs[i].strb;
            #1;
            check($sformatf("vec%0d_ctrl", i), {ctrl_in_req, ctrl_in_ready, ctrl_out_ready}, vecs[i].exp_ctrl);
            check($sformatf("vec%0d_breq", i), bulk_in_req, vecs[i].exp_breq);
            check($sformatf("vec%0d_brdy", i), bulk_in_ready, vecs[i].exp_brdy);
            check($sformatf("vec%0d_bordy", i), bulk_out_ready, vecs[i].exp_bordy);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_valid", i), in_valid, vecs[i].exp_valid);
            if (!vecs[i].exp_stall) check($sformatf("vec%0d_data", i), in_data, vecs[i].exp_data);
            if (vecs[i].endp != 4'd0) check($sformatf("vec%0d_nak", i), out_nak, vecs[i].exp_nak);
            idle_inputs();
        end
        endp = 4'd0; ctrl_stall = 1; ctrl_in_zlp = 1; #1;
        check("ctrl_stall_pass", stall, 1'b1);
        check("ctrl_zlp_pass", in_zlp, 1'b1);
        ctrl_stall = 0; ctrl_in_zlp = 0;
        @(negedge clk);

        // 4-byte IN on channel 2 leaves no ZLP pending
        endp = 4'd5; bulk_in_valid = 3'b100; in_req = 1; #1;
        check("t1_req", bulk_in_req, 3'b100);
        check("t1_ctrl_req", ctrl_in_req, 1'b0);
        tick(); in_req = 0; in_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1 check("t1_rdy", bulk_in_ready, 3'b100);
            tick();
        end
        in_ready = 0; bulk_in_valid = 3'b000; in_data_ack = 1; tick();
        in_data_ack = 0; tick();
        in_req = 1; #1;
        check("t1_no_zlp", in_zlp, 1'b0);
        in_req = 0;

        // Full 8-byte IN on channel 0, then ZLP, NAK replay, data overriding ZLP
        endp = 4'd1; bulk_in_valid = 3'b001; in_req = 1; tick();
        in_req = 0; in_ready = 1; repeat (8) tick();
        in_ready = 0; tick(); in_data_ack = 1; tick(); in_data_ack = 0;
        bulk_in_valid = 3'b000; in_req = 1; #1;
        check("t2_zlp", in_zlp, 1'b1);
        check("t2_zlp_valid", in_valid, 1'b0);
        tick(); in_req = 0; tick();
        in_req = 1; #1;
        check("t2_zlp_after_nak", in_zlp, 1'b1);
        tick(); in_req = 0; in_ready = 1; tick(); in_ready = 0; in_data_ack = 1; tick(); in_data_ack = 0;
        in_req = 1; #1;
        check("t2_zlp_cleared", in_zlp, 1'b0);
        in_req = 0; bulk_in_valid = 3'b001; tick(); in_ready = 1; repeat (8) tick();
        in_ready = 0; in_data_ack = 1; tick(); in_data_ack = 0;
        in_req = 1; #1;
        check("t2_data_over_zlp", in_zlp, 1'b0);
        tick(); in_req = 0; in_ready = 1; repeat (3) tick();
        in_ready = 0; in_data_ack = 1; tick(); in_data_ack = 0; bulk_in_valid = 3'b000;
        in_req = 1; #1;
        check("t2_short_no_zlp", in_zlp, 1'b0);
        in_req = 0; tick();

        // Halt set/clear on endpoint 3, clear-wins, ignored endpoints
        halt_endp = 4'd3; halt_set = 1; tick(); halt_set = 0; #1;
        check("t3_halted", halted, 3'b010);
        endp = 4'd3; bulk_in_valid = 3'b010; bulk_out_nak = 3'b010; in_req = 1; #1;
        check("t3_in_stall", stall, 1'b1);
        check("t3_in_noreq", bulk_in_req, 3'b000);
        check("t3_in_novalid", in_valid, 1'b0);
        in_req = 0; out_ready = 1; #1;
        check("t3_out_stall", stall, 1'b1);
        check("t3_out_nostrobe", bulk_out_ready, 3'b000);
        check("t3_out_nonak", out_nak, 1'b0);
        out_ready = 0; halt_clr = 1; tick(); halt_clr = 0; #1;
        check("t3_cleared", halted, 3'b000);
        check("t3_toggle", toggle_reset, 16'h0008);
        tick(); #1;
        check("t3_toggle_end", toggle_reset, 16'h0000);
        halt_endp = 4'd5; halt_set = 1; halt_clr = 1; tick(); halt_set = 0; halt_clr = 0; #1;
        check("t3_clr_wins", halted, 3'b000);
        check("t3_clr_toggle", toggle_reset, 16'h0020);
        halt_endp = 4'd0; halt_set = 1; tick(); #1;
        check("t3_ep0_ignored", halted, 3'b000);
        halt_endp = 4'd7; tick(); halt_set = 0; #1;
        check("t3_ep7_ignored", halted, 3'b000);
        check("t3_ep7_no_toggle", toggle_reset, 16'h0000);
        tick();

        // Endpoint change during BUSY stays on channel 0
        endp = 4'd1; in_req = 1; tick();
        in_req = 0; endp = 4'd3; in_ready = 1; #1;
        check("t4_held", bulk_in_ready, 3'b001);
        tick(); #1;
        check("t4_held2", bulk_in_ready, 3'b001);
        in_ready = 0; tick();
        in_req = 1; #1;
        check("t4_new_sel", bulk_in_req, 3'b010);
        in_req = 0;

        // Bus reset mid-transaction with ZLP pending and a halted channel
        endp = 4'd1; bulk_in_valid = 3'b001; in_req = 1; tick();
        in_req = 0; in_ready = 1; repeat (8) tick();
        in_ready = 0; in_data_ack = 1; tick(); in_data_ack = 0;
        halt_endp = 4'd5; halt_set = 1; tick(); halt_set = 0; #1;
        check("t6_pre_halted", halted, 3'b100);
        in_req = 1; tick(); in_req = 0; in_ready = 1; repeat (3) tick();
        bus_reset = 1; #1;
        check("t6_no_strobe", bulk_in_ready, 3'b000);
        tick(); #1;
        check("t6_halted", halted, 3'b000);
        check("t6_toggle", toggle_reset, 16'h0000);
        bus_reset = 0; in_ready = 0; bulk_in_valid = 3'b000; tick();
        in_req = 1; #1;
        check("t6_pend_clear", in_zlp, 1'b0);
        tick(); in_req = 0; bulk_in_valid = 3'b001; in_ready = 1; repeat (5) tick();
        in_ready = 0; in_data_ack = 1; tick(); in_data_ack = 0; bulk_in_valid = 3'b000;
        in_req = 1; #1;
        check("t6_cnt_clear", in_zlp, 1'b0);
        in_req = 0; tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 70) endp = 4'(BASE + STRIDE * $urandom_range(0, CH - 1));
            else endp = 4'($urandom_range(0, 15));
            in_req        = ($urandom_range(0, 9) == 0);
            in_ready      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 7) == 0);
            in_data_ack   = ($urandom_range(0, 15) == 0);
            bulk_in_valid = 3'($urandom) | 3'($urandom);
            bulk_in_data  = 24'($urandom);
            bulk_out_nak  = 3'($urandom);
            ctrl_in_data  = 8'($urandom);
            ctrl_in_valid = 1'($urandom);
            ctrl_in_zlp   = 1'($urandom);
            ctrl_stall    = 1'($urandom);
            halt_set      = ($urandom_range(0, 19) == 0);
            halt_clr      = ($urandom_range(0, 24) == 0);
            halt_endp     = 4'($urandom_range(0, 7));
            bus_reset     = ($urandom_range(0, 199) == 0);
            #1 check_model($sformatf("rand%0d", i));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
